// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath and its main control FSM.
// master: datapath side (drives opcode/flags, consumes controls)
// slave : controller side
interface multicycle_ctrl_if;
   logic [5:0] i_op;
   logic       i_zero;
   logic       i_memready;
   logic       o_instrwrite;
   logic       o_regdst;
   logic       o_regwrite;
   logic       o_memtoreg;
   logic       o_memread;
   logic       o_memwrite;
   logic       o_iord;
   logic       o_alusrca;
   logic [1:0] o_alusrcb;
   logic [1:0] o_aluop;
   logic [1:0] o_pcsrc;
   logic       o_pcen;
   logic       o_done;
   logic       o_illegal;
   logic [3:0] o_state;

   modport master (
      output i_op, i_zero, i_memready,
      input  o_instrwrite, o_regdst, o_regwrite, o_memtoreg, o_memread,
             o_memwrite, o_iord, o_alusrca, o_alusrcb, o_aluop, o_pcsrc,
             o_pcen, o_done, o_illegal, o_state
   );

   modport slave (
      input  i_op, i_zero, i_memready,
      output o_instrwrite, o_regdst, o_regwrite, o_memtoreg, o_memread,
             o_memwrite, o_iord, o_alusrca, o_alusrcb, o_aluop, o_pcsrc,
             o_pcen, o_done, o_illegal, o_state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath.
//
// state   | code | meaning
// --------+------+-----------------------------------------------
// FETCH   |  0   | read instruction at PC, PC += 4 when memory ready
// DECODE  |  1   | dispatch on opcode, precompute branch target
// MEMADR  |  2   | effective address = A + sign-extended imm
// MEMRD   |  3   | load data read, waits for memory ready
// MEMWB   |  4   | write loaded data into rt
// MEMWR   |  5   | store data write, waits for memory ready
// RTYPEEX |  6   | ALU operation selected by funct
// RTYPEWB |  7   | write ALU result into rd
// BEQEX   |  8   | compare A-B, take branch when zero
// ADDIEX  |  9   | A + sign-extended imm
// ADDIWB  | 10   | write ALU result into rt
// JEX     | 11   | load jump target into PC
// 12..15 are unreachable; they decode to all-idle outputs and return to FETCH.
module multicycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_J     = 6'h02
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   multicycle_ctrl_if.slave       bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   state_t state_q;
   state_t state_d;

   // State register; reset returns to FETCH immediately, even mid-instruction.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= FETCH;
      else         state_q <= state_d;
   end

   // Next-state and Moore output decode (memready/zero qualify a few strobes).
   always_comb begin
      state_d          = FETCH;
      bus.o_instrwrite = 1'b0;
      bus.o_regdst     = 1'b0;
      bus.o_regwrite   = 1'b0;
      bus.o_memtoreg   = 1'b0;
      bus.o_memread    = 1'b0;
      bus.o_memwrite   = 1'b0;
      bus.o_iord       = 1'b0;
      bus.o_alusrca    = 1'b0;
      bus.o_alusrcb    = 2'b00;
      bus.o_aluop      = 2'b00;
      bus.o_pcsrc      = 2'b00;
      bus.o_pcen       = 1'b0;
      bus.o_done       = 1'b0;
      bus.o_illegal    = 1'b0;

      case (state_q)
         FETCH: begin
            bus.o_memread    = 1'b1;
            bus.o_alusrcb    = 2'b01;
            bus.o_instrwrite = bus.i_memready;
            bus.o_pcen       = bus.i_memready;
            state_d          = bus.i_memready ? DECODE : FETCH;
         end
         DECODE: begin
            bus.o_alusrcb = 2'b11;
            if (bus.i_op == OP_LW || bus.i_op == OP_SW) state_d = MEMADR;
            else if (bus.i_op == OP_RTYPE)             state_d = RTYPEEX;
            else if (bus.i_op == OP_BEQ)               state_d = BEQEX;
            else if (bus.i_op == OP_ADDI)              state_d = ADDIEX;
            else if (bus.i_op == OP_J)                 state_d = JEX;
            else begin
               bus.o_illegal = 1'b1;
               state_d       = FETCH;
            end
         end
         MEMADR: begin
            bus.o_alusrca = 1'b1;
            bus.o_alusrcb = 2'b10;
            // Opcode is stable from the IR; anything else here cannot occur
            // but falls back to FETCH rather than guessing a direction.
            if (bus.i_op == OP_LW)      state_d = MEMRD;
            else if (bus.i_op == OP_SW) state_d = MEMWR;
            else                        state_d = FETCH;
         end
         MEMRD: begin
            bus.o_memread = 1'b1;
            bus.o_iord    = 1'b1;
            state_d       = bus.i_memready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.o_regwrite = 1'b1;
            bus.o_memtoreg = 1'b1;
            bus.o_done     = 1'b1;
            state_d        = FETCH;
         end
         MEMWR: begin
            bus.o_memwrite = 1'b1;
            bus.o_iord     = 1'b1;
            bus.o_done     = bus.i_memready;
            state_d        = bus.i_memready ? FETCH : MEMWR;
         end
         RTYPEEX: begin
            bus.o_alusrca = 1'b1;
            bus.o_aluop   = 2'b10;
            state_d       = RTYPEWB;
         end
         RTYPEWB: begin
            bus.o_regwrite = 1'b1;
            bus.o_regdst   = 1'b1;
            bus.o_done     = 1'b1;
            state_d        = FETCH;
         end
         BEQEX: begin
            bus.o_alusrca = 1'b1;
            bus.o_aluop   = 2'b01;
            bus.o_pcsrc   = 2'b01;
            bus.o_pcen    = bus.i_zero;
            bus.o_done    = 1'b1;
            state_d       = FETCH;
         end
         ADDIEX: begin
            bus.o_alusrca = 1'b1;
            bus.o_alusrcb = 2'b10;
            state_d       = ADDIWB;
         end
         ADDIWB: begin
            bus.o_regwrite = 1'b1;
            bus.o_done     = 1'b1;
            state_d        = FETCH;
         end
         JEX: begin
            bus.o_pcsrc = 2'b10;
            bus.o_pcen  = 1'b1;
            bus.o_done  = 1'b1;
            state_d     = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign bus.o_state = state_q;

endmodule
